// File: rtl/apb3_uart_completer.sv
// ----------------------------------------------------------------------------
// apb3_uart_completer
//
// APB3 completer that turns register accesses into 8N1 serial traffic.
// Bytes written to DATA are queued in a TX FIFO and shifted out on tx_o. Frames
// received on rx_i are deserialised into an RX FIFO that is drained by reading
// DATA. Register map (paddr[3:0]): DATA 0x0, STATUS 0x4, DIV 0x8.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   paddr .. pwdata   APB3 request (select, enable, direction, address, data)
//   prdata, pready,   APB3 response; zero wait states, pready follows
//   pslverr           pselx & penable
//   tx_o              serial transmit line, idles high
//   rx_i              serial receive line, asynchronous to clk
//   irq_o             RX FIFO not empty, or any sticky error flag set
// ----------------------------------------------------------------------------
module apb3_uart_completer #(
   parameter int          AddressWidth = 20,
   parameter int          DataWidth    = 32,
   parameter int          FifoDepth    = 8,
   parameter logic [15:0] DivReset     = 16'd868
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [AddressWidth-1:0] paddr,
   input  logic                    pselx,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DataWidth-1:0]    pwdata,
   output logic [DataWidth-1:0]    prdata,
   output logic                    pready,
   output logic                    pslverr,
   output logic                    tx_o,
   input  logic                    rx_i,
   output logic                    irq_o
);

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   localparam int                PtrW    = $clog2(FifoDepth) + 1;
   localparam int                IdxW    = PtrW - 1;
   localparam logic [PtrW-1:0]   PtrOne  = 1;
   localparam logic [15:0]       CntOne  = 16'd1;
   localparam logic [15:0]       DivMin  = 16'd2;
   localparam logic [DataWidth-1:0] StatusW1cMask = 'h30;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } txState_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT
   } rxState_t;

   // ---------------------------------------------------------------------------
   // Register and wire declarations
   // ---------------------------------------------------------------------------
   logic [15:0]     r_div;
   logic            r_overrun;
   logic            r_frameErr;

   logic [7:0]      r_txMem [FifoDepth];
   logic [PtrW-1:0] r_txWp;
   logic [PtrW-1:0] r_txRp;
   logic [7:0]      r_rxMem [FifoDepth];
   logic [PtrW-1:0] r_rxWp;
   logic [PtrW-1:0] r_rxRp;

   txState_t        r_txState;
   txState_t        w_txStateNext;
   logic [15:0]     r_txCnt;
   logic [15:0]     w_txCntNext;
   logic [15:0]     r_txDiv;
   logic [15:0]     w_txDivNext;
   logic [7:0]      r_txShift;
   logic [7:0]      w_txShiftNext;
   logic [2:0]      r_txBit;
   logic [2:0]      w_txBitNext;
   logic            r_txLine;
   logic            w_txLineNext;
   logic            w_txBitEnd;
   logic            w_txPop;

   logic            r_rxSync1;
   logic            r_rxSync2;
   logic            r_rxPrev;
   rxState_t        r_rxState;
   rxState_t        w_rxStateNext;
   logic [15:0]     r_rxCnt;
   logic [15:0]     w_rxCntNext;
   logic [15:0]     r_rxDiv;
   logic [15:0]     w_rxDivNext;
   logic [7:0]      r_rxShift;
   logic [7:0]      w_rxShiftNext;
   logic [2:0]      r_rxBit;
   logic [2:0]      w_rxBitNext;
   logic            w_rxBitEnd;
   logic            w_rxHalfEnd;
   logic            w_rxFall;
   logic            w_rxStopGood;
   logic            w_frameErrSet;

   logic            w_access;
   logic [3:0]      w_offset;
   logic            w_selData;
   logic            w_selStatus;
   logic            w_selDiv;
   logic            w_unmapped;
   logic            w_statusBadBits;
   logic            w_txFull;
   logic            w_txEmpty;
   logic            w_rxFull;
   logic            w_rxEmpty;
   logic            w_txPush;
   logic            w_txDrop;
   logic            w_rxPop;
   logic            w_rxPush;
   logic            w_overrunSet;
   logic            w_statusWrite;
   logic            w_divWrite;
   logic            w_err;
   logic [DataWidth-1:0] w_rdata;
   logic            w_unusedAddrBits;

   // ---------------------------------------------------------------------------
   // APB decode. Only the low nibble of the address selects a register.
   // ---------------------------------------------------------------------------
   assign w_access         = pselx & penable;
   assign w_offset         = paddr[3:0];
   assign w_unusedAddrBits = ^paddr[AddressWidth-1:4];
   assign w_selData        = (w_offset == 4'h0);
   assign w_selStatus      = (w_offset == 4'h4);
   assign w_selDiv         = (w_offset == 4'h8);
   assign w_unmapped       = ~(w_selData | w_selStatus | w_selDiv);
   assign w_statusBadBits  = |(pwdata & ~StatusW1cMask);

   assign w_txEmpty = (r_txWp == r_txRp);
   assign w_txFull  = (r_txWp[IdxW] != r_txRp[IdxW]) &&
                      (r_txWp[IdxW-1:0] == r_txRp[IdxW-1:0]);
   assign w_rxEmpty = (r_rxWp == r_rxRp);
   assign w_rxFull  = (r_rxWp[IdxW] != r_rxRp[IdxW]) &&
                      (r_rxWp[IdxW-1:0] == r_rxRp[IdxW-1:0]);

   // A push into a full TX FIFO still lands if the shifter frees a slot in the
   // same cycle; only a genuinely full FIFO drops the byte.
   assign w_txDrop = w_access & pwrite & w_selData & w_txFull & ~w_txPop;
   assign w_txPush = w_access & pwrite & w_selData & ~w_txDrop;

   assign w_rxPop  = w_access & ~pwrite & w_selData & ~w_rxEmpty;

   // Likewise an RX byte is kept when the bus drains a full FIFO that cycle.
   assign w_rxPush     = w_rxStopGood & (~w_rxFull | w_rxPop);
   assign w_overrunSet = w_rxStopGood & w_rxFull & ~w_rxPop;

   assign w_statusWrite = w_access & pwrite & w_selStatus & ~w_statusBadBits;
   assign w_divWrite    = w_access & pwrite & w_selDiv;

   assign w_err = w_access & (w_unmapped |
                              (pwrite & w_selStatus & w_statusBadBits) |
                              w_txDrop);

   // Read mux; the bus sees zero outside the access phase.
   always_comb begin
      w_rdata = '0;
      if (w_access && !pwrite) begin
         if (w_selData) begin
            if (!w_rxEmpty) begin
               w_rdata[7:0] = r_rxMem[r_rxRp[IdxW-1:0]];
            end
         end else if (w_selStatus) begin
            w_rdata[6:0] = {(r_txState != TX_IDLE), r_frameErr, r_overrun,
                            w_rxEmpty, w_rxFull, w_txEmpty, w_txFull};
         end else if (w_selDiv) begin
            w_rdata[15:0] = r_div;
         end
      end
   end

   assign prdata  = rst_n ? w_rdata : '0;
   assign pready  = rst_n & w_access;
   assign pslverr = rst_n & w_err;
   assign tx_o    = r_txLine;
   assign irq_o   = ~w_rxEmpty | r_overrun | r_frameErr;

   // ---------------------------------------------------------------------------
   // Control registers. Divisors below 2 are clamped so the RX half-bit wait is
   // never zero. A flag being set in the same cycle as its W1C clear stays set.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div      <= DivReset;
         r_overrun  <= 1'b0;
         r_frameErr <= 1'b0;
      end else begin
         if (w_divWrite) begin
            r_div <= (pwdata[15:0] < DivMin) ? DivMin : pwdata[15:0];
         end
         if (w_overrunSet) begin
            r_overrun <= 1'b1;
         end else if (w_statusWrite && pwdata[4]) begin
            r_overrun <= 1'b0;
         end
         if (w_frameErrSet) begin
            r_frameErr <= 1'b1;
         end else if (w_statusWrite && pwdata[5]) begin
            r_frameErr <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO storage and pointers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_txPush) begin
         r_txMem[r_txWp[IdxW-1:0]] <= pwdata[7:0];
      end
      if (w_rxPush) begin
         r_rxMem[r_rxWp[IdxW-1:0]] <= r_rxShift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txWp <= '0;
         r_txRp <= '0;
         r_rxWp <= '0;
         r_rxRp <= '0;
      end else begin
         if (w_txPush) r_txWp <= r_txWp + PtrOne;
         if (w_txPop)  r_txRp <= r_txRp + PtrOne;
         if (w_rxPush) r_rxWp <= r_rxWp + PtrOne;
         if (w_rxPop)  r_rxRp <= r_rxRp + PtrOne;
      end
   end

   // ---------------------------------------------------------------------------
   // TX FSM. The divisor is captured at each frame start so a DIV write never
   // stretches a frame in flight. tx_o is registered from the next-state value
   // so the line is glitch-free and tracks the state exactly.
   // ---------------------------------------------------------------------------
   assign w_txBitEnd = (r_txCnt == r_txDiv - CntOne);

   always_comb begin
      w_txStateNext = r_txState;
      w_txCntNext   = r_txCnt;
      w_txDivNext   = r_txDiv;
      w_txShiftNext = r_txShift;
      w_txBitNext   = r_txBit;
      w_txPop       = 1'b0;
      w_txLineNext  = 1'b1;
      case (r_txState)
         TX_IDLE: begin
            if (!w_txEmpty) begin
               w_txPop       = 1'b1;
               w_txShiftNext = r_txMem[r_txRp[IdxW-1:0]];
               w_txDivNext   = r_div;
               w_txCntNext   = '0;
               w_txStateNext = TX_START;
            end
         end
         TX_START: begin
            if (w_txBitEnd) begin
               w_txCntNext   = '0;
               w_txBitNext   = '0;
               w_txStateNext = TX_DATA;
            end else begin
               w_txCntNext = r_txCnt + CntOne;
            end
         end
         TX_DATA: begin
            if (w_txBitEnd) begin
               w_txCntNext   = '0;
               w_txShiftNext = {1'b1, r_txShift[7:1]};
               if (r_txBit == 3'd7) begin
                  w_txStateNext = TX_STOP;
               end else begin
                  w_txBitNext = r_txBit + 3'd1;
               end
            end else begin
               w_txCntNext = r_txCnt + CntOne;
            end
         end
         TX_STOP: begin
            if (w_txBitEnd) begin
               w_txCntNext = '0;
               if (!w_txEmpty) begin
                  w_txPop       = 1'b1;
                  w_txShiftNext = r_txMem[r_txRp[IdxW-1:0]];
                  w_txDivNext   = r_div;
                  w_txStateNext = TX_START;
               end else begin
                  w_txStateNext = TX_IDLE;
               end
            end else begin
               w_txCntNext = r_txCnt + CntOne;
            end
         end
         default: w_txStateNext = TX_IDLE;
      endcase
      case (w_txStateNext)
         TX_START: w_txLineNext = 1'b0;
         TX_DATA:  w_txLineNext = w_txShiftNext[0];
         default:  w_txLineNext = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txState <= TX_IDLE;
         r_txCnt   <= '0;
         r_txDiv   <= DivReset;
         r_txShift <= '0;
         r_txBit   <= '0;
         r_txLine  <= 1'b1;
      end else begin
         r_txState <= w_txStateNext;
         r_txCnt   <= w_txCntNext;
         r_txDiv   <= w_txDivNext;
         r_txShift <= w_txShiftNext;
         r_txBit   <= w_txBitNext;
         r_txLine  <= w_txLineNext;
      end
   end

   // ---------------------------------------------------------------------------
   // RX synchroniser plus one history flop for falling-edge detection. All flops
   // reset high so leaving reset never looks like a start bit.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxSync1 <= 1'b1;
         r_rxSync2 <= 1'b1;
         r_rxPrev  <= 1'b1;
      end else begin
         r_rxSync1 <= rx_i;
         r_rxSync2 <= r_rxSync1;
         r_rxPrev  <= r_rxSync2;
      end
   end

   assign w_rxFall    = r_rxPrev & ~r_rxSync2;
   assign w_rxBitEnd  = (r_rxCnt == r_rxDiv - CntOne);
   assign w_rxHalfEnd = (r_rxCnt == (r_rxDiv >> 1) - CntOne);

   // ---------------------------------------------------------------------------
   // RX FSM. The start bit is re-checked at mid-bit to reject glitches; every
   // later sample lands a whole bit period after that, i.e. mid-bit. After a
   // bad stop bit the receiver waits for the line to go idle so a held-low
   // line does not retrigger frames.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_rxStateNext = r_rxState;
      w_rxCntNext   = r_rxCnt;
      w_rxDivNext   = r_rxDiv;
      w_rxShiftNext = r_rxShift;
      w_rxBitNext   = r_rxBit;
      w_rxStopGood  = 1'b0;
      w_frameErrSet = 1'b0;
      case (r_rxState)
         RX_IDLE: begin
            if (w_rxFall) begin
               w_rxCntNext   = '0;
               w_rxDivNext   = r_div;
               w_rxStateNext = RX_START;
            end
         end
         RX_START: begin
            if (w_rxHalfEnd) begin
               w_rxCntNext = '0;
               if (r_rxSync2) begin
                  w_rxStateNext = RX_IDLE;
               end else begin
                  w_rxBitNext   = '0;
                  w_rxStateNext = RX_DATA;
               end
            end else begin
               w_rxCntNext = r_rxCnt + CntOne;
            end
         end
         RX_DATA: begin
            if (w_rxBitEnd) begin
               w_rxCntNext   = '0;
               w_rxShiftNext = {r_rxSync2, r_rxShift[7:1]};
               if (r_rxBit == 3'd7) begin
                  w_rxStateNext = RX_STOP;
               end else begin
                  w_rxBitNext = r_rxBit + 3'd1;
               end
            end else begin
               w_rxCntNext = r_rxCnt + CntOne;
            end
         end
         RX_STOP: begin
            if (w_rxBitEnd) begin
               w_rxCntNext = '0;
               if (r_rxSync2) begin
                  w_rxStopGood  = 1'b1;
                  w_rxStateNext = RX_IDLE;
               end else begin
                  w_frameErrSet = 1'b1;
                  w_rxStateNext = RX_WAIT;
               end
            end else begin
               w_rxCntNext = r_rxCnt + CntOne;
            end
         end
         RX_WAIT: begin
            if (r_rxSync2) begin
               w_rxStateNext = RX_IDLE;
            end
         end
         default: w_rxStateNext = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxState <= RX_IDLE;
         r_rxCnt   <= '0;
         r_rxDiv   <= DivReset;
         r_rxShift <= '0;
         r_rxBit   <= '0;
      end else begin
         r_rxState <= w_rxStateNext;
         r_rxCnt   <= w_rxCntNext;
         r_rxDiv   <= w_rxDivNext;
         r_rxShift <= w_rxShiftNext;
         r_rxBit   <= w_rxBitNext;
      end
   end

endmodule

// File: doc/apb3_uart_completer.md
Name: apb3_uart_completer

Overview:
APB3 completer UART that sits directly downstream of the Renode-driven UART requester. It accepts the APB3 transfers the requester issues and converts them to 8N1 serial traffic on tx_o. It deserialises rx_i into an RX FIFO that the requester reads back over APB3. Register map: DATA 0x0, STATUS 0x4, DIV 0x8, all other offsets unmapped.

Parameters:
AddressWidth, 20, APB paddr width; only bits [3:0] are decoded.
DataWidth, 32, APB pwdata/prdata width; must be 32.
FifoDepth, 8, TX and RX FIFO depth in entries; must be a power of 2, minimum 2.
DivReset, 16'd868, reset value of DIV (clk cycles per bit).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
paddr  in  AddressWidth  APB address
pselx  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
pwdata  in  DataWidth  APB write data
prdata  out  DataWidth  APB read data
pready  out  1  APB ready
pslverr  out  1  APB error
tx_o  out  1  serial TX, idle high
rx_i  in  1  serial RX, asynchronous to clk
irq_o  out  1  level interrupt: RX FIFO not empty OR any sticky error set

Behaviour:
- Reset (async, rst_n=0):
  - tx_o=1, prdata=0, pready=0, pslverr=0, irq_o=0.
  - Both FIFOs empty; DIV=DivReset; sticky flags cleared; TX/RX FSMs to IDLE.
- Reset mid-frame aborts the frame immediately; tx_o returns to 1 in the same cycle as reset assertion.
- APB handshake:
  - Zero wait states: pready=1 combinationally whenever pselx&penable; otherwise 0.
  - Side effects (push, pop, register write) occur once, on the access-phase clk edge.
  - prdata is valid during the access phase.
  - pslverr=1 only in the access phase, in these cases: unmapped offset; write to STATUS with a bit other than [5:4] set; write to DATA while TX FIFO is full (data dropped).
- DATA write: pushes pwdata[7:0] into the TX FIFO.
- DATA read:
  - RX FIFO non-empty: pops the FIFO and returns {24'b0, byte}.
  - RX FIFO empty: returns 0 with pslverr=0 and no pop.
- STATUS read bits:
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty
  - [4] rx_overrun (sticky), [5] frame_err (sticky), [6] tx_busy (shifter active); others 0.
  - Writing 1 to bit 4 or bit 5 clears that flag (W1C).
- DIV register: [15:0] read/write, upper bits read as 0.
  - Written values below 2 are stored as 2.
  - A new DIV takes effect at the next frame start; frames in flight keep the old divisor.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state/bit lasts exactly DIV clk cycles.
  - In IDLE with TX FIFO non-empty: pop and enter START on the next cycle.
  - STOP goes straight to START (back-to-back, no idle gap) if the FIFO is non-empty.
  - tx_busy=1 in every state except IDLE.
- RX path: rx_i passes through a 2-flop synchroniser, giving 2 cycles of input latency.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: a synchronised falling edge starts the frame.
  - START: wait DIV/2 cycles (floor), then re-sample. If high, treat as a glitch and return to IDLE.
  - DATA: sample every DIV cycles thereafter, 8 bits, LSB first.
  - STOP: sample the stop bit at mid-bit.
    - Stop=1: push the byte. If the RX FIFO is full, drop the byte and set rx_overrun; FIFO contents are unchanged.
    - Stop=0: discard the byte, set frame_err, and wait for rx=1 before returning to IDLE.
- Simultaneous events:
  - APB pop and RX push in the same cycle on a full FIFO: both succeed, no overrun.
  - APB push and TX pop in the same cycle on a full FIFO: push accepted.
  - W1C clear and a new set in the same cycle: set wins.
- FIFO pointers are log2(FifoDepth)+1 bits and wrap modulo 2*FifoDepth; full/empty are derived from the MSB compare.

Test Plan:
- Reset, then read STATUS -> 0x0000_000A (tx_empty, rx_empty); read DIV -> 868; tx_o=1; irq_o=0.
- DIV=4, write DATA 0xA5 -> tx_o low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; tx_busy deasserts after 40 cycles.
- DIV=4, write 9 bytes with FifoDepth=8 and shifter busy -> the 9th write returns pslverr=1; first 8 bytes transmitted back-to-back with no idle gap.
- DIV=8, drive 0x3C on rx_i -> irq_o=1; DATA read returns 0x3C; next STATUS read shows rx_empty=1 and irq_o=0.
- Drive 9 frames without reading -> rx_overrun=1; FIFO holds the first 8 bytes; write STATUS 0x10 clears rx_overrun.
- Frame with stop bit 0 -> frame_err=1 and no push. Separately: 2-cycle low glitch at DIV=8 -> no frame. Separately: access to offset 0xC -> pslverr=1.
